bit_serial_addsub: RTL

//   Parametrised bit-serial adder/subtractor. Parallel operands are loaded on a start pulse
//   and processed LSB-first, one bit per clock, through a single full adder and carry flop.

---
 rtl/bit_serial_addsub.sv | 78 +++++++
 1 files changed

// File: rtl/bit_serial_addsub.sv
// bit_serial_addsub: LSB-first bit-serial adder/subtractor, one full adder + carry flop.
// Start/busy/done handshake; result, carry-out and signed overflow held from done to next start.
module bit_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CNTW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CNTW-1:0] cnt;
    logic carry, accept, last, s, c_nxt;

    always_comb begin
        accept    = start && state != SHIFT;
        last      = cnt == CNTW'(WIDTH - 1);
        s         = a_sr[0] ^ b_sr[0] ^ carry;
        c_nxt     = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        state_nxt = state;
        if (accept)
            state_nxt = SHIFT;
        else if (state == SHIFT)
            state_nxt = last ? DONE : SHIFT;
        else if (state == DONE)
            state_nxt = IDLE;
        busy = state == SHIFT;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // a_sr doubles as the result shift register: sum bits enter at the MSB as operand bits leave
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= {s, a_sr[WIDTH-1:1]};
            b_sr  <= b_sr >> 1;
            carry <= c_nxt;
            cnt   <= cnt + CNTW'(1);
            if (last) begin
                sum      <= {s, a_sr[WIDTH-1:1]};
                cout     <= c_nxt;
                overflow <= carry ^ c_nxt;
            end
        end
    end
endmodule
